// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
// Shares the two ports of a true dual-port RAM between NREQ single-word
// requesters. Each cycle up to two accesses are issued, one per RAM port,
// under round-robin priority. Port B is dropped when it would touch the same
// address as port A with at least one of them writing. Read data returns
// two cycles after the grant to the requester that issued the read.
//
// Optional build feature, enabled by defining DPRAM_ARB_COLL_CNT_EN:
// a saturating 16-bit coll_cnt output counting dropped port-B candidates.
module dpram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic              ena,
    output logic              wea,
    output logic [AW-1:0]     addra,
    output logic [DW-1:0]     data_i_a,
    input  logic [DW-1:0]     data_o_a,
    output logic              enb,
    output logic              web,
    output logic [AW-1:0]     addrb,
    output logic [DW-1:0]     data_i_b,
    input  logic [DW-1:0]     data_o_b
`ifdef DPRAM_ARB_COLL_CNT_EN
    ,
    output logic [15:0]       coll_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Circular index: (base + off) mod NREQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return PW'(sum % NREQ);
    endfunction

    // Unpacked views of the flat per-requester buses
    logic [AW-1:0] addr_arr_s  [NREQ];
    logic [DW-1:0] wdata_arr_s [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr_s[g]  = addr[g*AW +: AW];
        assign wdata_arr_s[g] = wdata[g*DW +: DW];
    end

    // Registered state
    logic [PW-1:0]     ptr_r;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   rvalid_r;
    logic [NREQ*DW-1:0] rdata_r;
    logic              ena_r, wea_r, enb_r, web_r;
    logic [AW-1:0]     addra_r, addrb_r;
    logic [DW-1:0]     data_a_r, data_b_r;
    // Read tags: stage 1 is set at the grant edge, stage 2 one edge later
    // when the RAM has sampled the address; data is captured one edge after.
    logic              tag1_a_vld_r, tag1_b_vld_r, tag2_a_vld_r, tag2_b_vld_r;
    logic [PW-1:0]     tag1_a_idx_r, tag1_b_idx_r, tag2_a_idx_r, tag2_b_idx_r;

    // Arbitration signals
    logic [NREQ-1:0]   eligible_s;
    logic              a_found_s, b_cand_s, b_gnt_s, conflict_s;
    logic [PW-1:0]     a_idx_s, b_idx_s, ptr_nxt_s;
    logic [NREQ-1:0]   gnt_nxt_s;
    logic [NREQ-1:0]   rvalid_nxt_s;
    logic [NREQ*DW-1:0] rdata_nxt_s;
    logic              take_a_s, take_b_s;

    // A requester showing gnt this cycle is not re-granted on the next edge
    assign eligible_s = req & ~gnt_r;

    // Port A winner: first eligible scanning from ptr; port B: from a+1, excluding a
    always_comb begin
        a_found_s = 1'b0;
        a_idx_s   = '0;
        b_cand_s  = 1'b0;
        b_idx_s   = '0;
        take_a_s  = 1'b0;
        take_b_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            take_a_s  = ~a_found_s & eligible_s[wrap_idx(ptr_r, k)];
            a_idx_s   = take_a_s ? wrap_idx(ptr_r, k) : a_idx_s;
            a_found_s = a_found_s | take_a_s;
        end
        for (int k = 0; k < NREQ - 1; k++) begin
            take_b_s = a_found_s & ~b_cand_s & eligible_s[wrap_idx(a_idx_s, k + 1)];
            b_idx_s  = take_b_s ? wrap_idx(a_idx_s, k + 1) : b_idx_s;
            b_cand_s = b_cand_s | take_b_s;
        end
    end

    // Same-address hazard: only two reads may share an address
    assign conflict_s = b_cand_s
                      & (addr_arr_s[a_idx_s] == addr_arr_s[b_idx_s])
                      & (we[a_idx_s] | we[b_idx_s]);
    assign b_gnt_s    = b_cand_s & ~conflict_s;

    // Next grant vector and round-robin pointer
    always_comb begin
        gnt_nxt_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_nxt_s[i] = (a_found_s && (a_idx_s == PW'(i))) ||
                           (b_gnt_s   && (b_idx_s == PW'(i)));
        end
        ptr_nxt_s = b_gnt_s   ? wrap_idx(b_idx_s, 1) :
                    a_found_s ? wrap_idx(a_idx_s, 1) : ptr_r;
    end

    // Register the arbitration result onto the RAM ports and read tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r        <= '0;
            gnt_r        <= '0;
            ena_r        <= 1'b0;
            wea_r        <= 1'b0;
            addra_r      <= '0;
            data_a_r     <= '0;
            enb_r        <= 1'b0;
            web_r        <= 1'b0;
            addrb_r      <= '0;
            data_b_r     <= '0;
            tag1_a_vld_r <= 1'b0;
            tag1_a_idx_r <= '0;
            tag1_b_vld_r <= 1'b0;
            tag1_b_idx_r <= '0;
            tag2_a_vld_r <= 1'b0;
            tag2_a_idx_r <= '0;
            tag2_b_vld_r <= 1'b0;
            tag2_b_idx_r <= '0;
        end else begin
            ptr_r        <= ptr_nxt_s;
            gnt_r        <= gnt_nxt_s;
            ena_r        <= a_found_s;
            wea_r        <= a_found_s & we[a_idx_s];
            enb_r        <= b_gnt_s;
            web_r        <= b_gnt_s & we[b_idx_s];
            if (a_found_s) begin
                addra_r  <= addr_arr_s[a_idx_s];
                data_a_r <= wdata_arr_s[a_idx_s];
            end
            if (b_gnt_s) begin
                addrb_r  <= addr_arr_s[b_idx_s];
                data_b_r <= wdata_arr_s[b_idx_s];
            end
            tag1_a_vld_r <= a_found_s & ~we[a_idx_s];
            tag1_a_idx_r <= a_idx_s;
            tag1_b_vld_r <= b_gnt_s & ~we[b_idx_s];
            tag1_b_idx_r <= b_idx_s;
            tag2_a_vld_r <= tag1_a_vld_r;
            tag2_a_idx_r <= tag1_a_idx_r;
            tag2_b_vld_r <= tag1_b_vld_r;
            tag2_b_idx_r <= tag1_b_idx_r;
        end
    end

    // Route RAM read data to the tagged requester; others hold their rdata
    always_comb begin
        rvalid_nxt_s = '0;
        rdata_nxt_s  = rdata_r;
        for (int i = 0; i < NREQ; i++) begin
            if (tag2_a_vld_r && (tag2_a_idx_r == PW'(i))) begin
                rvalid_nxt_s[i]          = 1'b1;
                rdata_nxt_s[i*DW +: DW]  = data_o_a;
            end else if (tag2_b_vld_r && (tag2_b_idx_r == PW'(i))) begin
                rvalid_nxt_s[i]          = 1'b1;
                rdata_nxt_s[i*DW +: DW]  = data_o_b;
            end else begin
                rvalid_nxt_s[i]          = 1'b0;
            end
        end
    end

    // Register read-return outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= '0;
            rdata_r  <= '0;
        end else begin
            rvalid_r <= rvalid_nxt_s;
            rdata_r  <= rdata_nxt_s;
        end
    end

`ifdef DPRAM_ARB_COLL_CNT_EN
    logic [15:0] coll_cnt_r;

    // Count dropped port-B candidates, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_cnt_r <= 16'h0000;
        end else if (b_cand_s && conflict_s && (coll_cnt_r != 16'hFFFF)) begin
            coll_cnt_r <= coll_cnt_r + 16'h0001;
        end
    end

    assign coll_cnt = coll_cnt_r;
`endif

    assign gnt      = gnt_r;
    assign rvalid   = rvalid_r;
    assign rdata    = rdata_r;
    assign ena      = ena_r;
    assign wea      = wea_r;
    assign addra    = addra_r;
    assign data_i_a = data_a_r;
    assign enb      = enb_r;
    assign web      = web_r;
    assign addrb    = addrb_r;
    assign data_i_b = data_b_r;

endmodule
